dmem_lsu: RTL and testbench

Load/store sequencer between the pipeline MEM stage and the word-addressed, word-write-only data memory (`data_mem`, combinational read, synchronous write). It accepts one RV32I load or store per handshake and decodes funct3. Sub-word stores run as a read-modify-write over two memory cycles. It returns sign- or zero-extended load data, or a fault for misaligned, out-of-range or illegal accesses.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/dmem_lsu_align.sv | 41 ++++
 rtl/dmem_lsu.sv | 132 +++++++++++++
 tb/tb_dmem_lsu.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned F3_W    = 3;

  localparam logic [F3_W-1:0] LB  = 3'b000;
  localparam logic [F3_W-1:0] LH  = 3'b001;
  localparam logic [F3_W-1:0] LW  = 3'b010;
  localparam logic [F3_W-1:0] LBU = 3'b100;
  localparam logic [F3_W-1:0] LHU = 3'b101;
  localparam logic [F3_W-1:0] SB  = 3'b000;
  localparam logic [F3_W-1:0] SH  = 3'b001;
  localparam logic [F3_W-1:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE, RESP} lsu_state_t;

  // Request fields kept for the operation in flight.
  typedef struct packed {
    logic            we;
    logic [F3_W-1:0] funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Halfwords need even addresses, words need 4-byte alignment.
  function automatic logic misaligned(input logic [F3_W-1:0] funct3, input logic [1:0] addr_lo);
    logic m;
    m = 1'b0;
    case (funct3[1:0])
      2'b01:   m = addr_lo[0];
      2'b10:   m = (addr_lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      addr_lo,
  input  logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] load_data_c,
  output logic [XLEN-1:0] merged_c
);

  logic [4:0]      sh;
  logic [XLEN-1:0] shifted;

  assign sh      = {addr_lo, 3'b000};
  assign shifted = word >> sh;

  always_comb begin
    load_data_c = '0;
    case (funct3)
      LB:      load_data_c = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_data_c = {{16{shifted[15]}}, shifted[15:0]};
      LW:      load_data_c = word;
      LBU:     load_data_c = {24'h0, shifted[7:0]};
      LHU:     load_data_c = {16'h0, shifted[15:0]};
      default: load_data_c = '0;
    endcase
  end

  // Replace only the addressed lanes of the old word.
  always_comb begin
    merged_c = word;
    case (funct3)
      SB:      merged_c = (word & ~(32'h0000_00FF << sh)) | ({24'h0, wdata[7:0]} << sh);
      SH:      merged_c = (word & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata[15:0]} << sh);
      default: merged_c = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer between the MEM stage and a word-write-only data memory.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [F3_W-1:0]     req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_fault,
  output logic [WADDR_W-1:0]  mem_addr,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_wd,
  input  logic [XLEN-1:0]     mem_rd
);

  lsu_state_t         state, state_d;
  lsu_req_t           req_q, req_d;
  logic               req_ready_d, resp_valid_d, resp_fault_d, mem_we_d;
  logic [XLEN-1:0]    resp_rdata_d, mem_wd_d;
  logic [WADDR_W-1:0] mem_addr_d;
  logic [XLEN-1:0]    load_data_c, merged_c;
  logic               f3_legal_c, out_of_range_c, fault_c;

  lsu_align u_align (
    .word        (mem_rd),
    .wdata       (req_q.wdata),
    .addr_lo     (req_q.addr_lo),
    .funct3      (req_q.funct3),
    .load_data_c (load_data_c),
    .merged_c    (merged_c)
  );

  // Request legality, evaluated on the live inputs at accept.
  always_comb begin
    f3_legal_c = 1'b0;
    if (req_we) f3_legal_c = (req_funct3 inside {SB, SH, SW});
    else        f3_legal_c = (req_funct3 inside {LB, LH, LW, LBU, LHU});
    out_of_range_c = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    fault_c = !f3_legal_c || misaligned(req_funct3, req_addr[1:0]) || out_of_range_c;
  end

  always_comb begin
    state_d      = state;
    req_d        = req_q;
    resp_valid_d = 1'b0;
    resp_fault_d = resp_fault;
    resp_rdata_d = resp_rdata;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wd_d     = mem_wd;
    case (state)
      IDLE: begin
        if (req_valid) begin
          req_d = '{we: req_we, funct3: req_funct3, addr_lo: req_addr[1:0], wdata: req_wdata};
          if (fault_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d    = EXEC;
            mem_addr_d = req_addr[31:2];
            // A full-word store needs no read, so it writes during EXEC.
            if (req_we && req_funct3 == SW) begin
              mem_we_d = 1'b1;
              mem_wd_d = req_wdata;
            end
          end
        end
      end
      EXEC: begin
        if (!req_q.we) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = load_data_c;
        end else if (req_q.funct3 == SW) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rdata_d = '0;
        end else begin
          state_d  = WRITE;
          mem_we_d = 1'b1;
          mem_wd_d = merged_c;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b0;
        resp_rdata_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
    end else begin
      state      <= state_d;
      req_q      <= req_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_fault <= resp_fault_d;
      resp_rdata <= resp_rdata_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wd     <= mem_wd_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: attached word memory, byte-level reference model, directed and random traffic.
module tb_dmem_lsu;
  import lsu_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd, mem_rd;
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = (mem_addr < 30'(DEPTH)) ? mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 30'(DEPTH)) mem[mem_addr[7:0]] <= mem_wd;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic poke(input int idx, input logic [31:0] v);
    poke_en = 1'b1; poke_idx = 8'(idx); poke_val = v;
    @(posedge clk);
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Reference: byte-granular rules, updates ref_mem for stores.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output logic exp_flt, output int exp_lat,
                       output logic [7:0] exp_we);
    int size, lane, idx;
    logic legal;
    longint v;
    logic [31:0] w;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lane = int'(a[1:0]);
    exp_rd = 32'h0; exp_we = 8'h0;
    exp_flt = !legal || (lane % size != 0) || (a / 4 >= DEPTH);
    exp_lat = 1;
    if (!exp_flt) begin
      idx = int'(a[31:2]);
      w = ref_mem[idx];
      if (!we) begin
        v = longint'(w >> (8 * lane)) & ((longint'(1) << (8 * size)) - 1);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
        exp_rd = 32'(v);
        exp_lat = 2;
      end else begin
        for (int i = 0; i < size; i++) w[8 * (lane + i) +: 8] = wd[8 * i +: 8];
        ref_mem[idx] = w;
        exp_lat = (size == 4) ? 2 : 3;
        exp_we = (size == 4) ? 8'b0000_0010 : 8'b0000_0100;
      end
    end
  endtask

  // Issues one request from a negedge, scrambles inputs after accept, returns at the response negedge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic flt,
                       output logic [7:0] we_mask, output logic [7:0] rdy_mask);
    lat = -1; rd = 32'h0; flt = 1'b0; we_mask = 8'h0; rdy_mask = 8'h0;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k < 8; k++) begin
      if (k > 1) @(negedge clk);
      we_mask[k] = mem_we;
      rdy_mask[k] = req_ready;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; flt = resp_fault;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++; if ({resp_valid, resp_fault, mem_we} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {resp_valid, resp_fault, mem_we}); end
    n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (mem_addr !== 30'h0 || mem_wd !== 32'h0) begin
      n_bad++; $display("FAIL reset_mem_bus: got addr %h wd %h want 0/0", mem_addr, mem_wd); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [5] = '{LB, LBU, LH, LHU, LW};
    logic [31:0] adr [5] = '{32'h0E, 32'h0F, 32'h0E, 32'h0C, 32'h0C};
    logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    int lat; logic [31:0] rd; logic flt; logic [7:0] wm, rm;
    poke(3, 32'h80FF_7F01);
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3s[i], adr[i], 32'h0, lat, rd, flt, wm, rm);
      n_cmp++; if (rd !== exp[i] || flt !== 1'b0) begin
        n_bad++; $display("FAIL load_ext[%0d]: got %h/%b want %h/0", i, rd, flt, exp[i]); end
      n_cmp++; if (lat !== 2 || wm !== 8'h0 || rm !== 8'h0) begin
        n_bad++; $display("FAIL load_ext_timing[%0d]: got lat %0d we %b rdy %b want 2/0/0", i, lat, wm, rm); end
    end
  endtask

  task automatic test_sb_rmw();
    int lat, el; logic [31:0] rd, er; logic flt, ef; logic [7:0] wm, rm, ew;
    poke(5, 32'h1122_3344);
    model(1'b1, SB, 32'h15, 32'hAAAA_AA99, er, ef, el, ew);
    issue(1'b1, SB, 32'h15, 32'hAAAA_AA99, lat, rd, flt, wm, rm);
    n_cmp++; if (lat !== 3 || wm !== 8'b0000_0100 || rm !== 8'h0) begin
      n_bad++; $display("FAIL sb_timing: got lat %0d we %b rdy %b want 3/00000100/0", lat, wm, rm); end
    n_cmp++; if (flt !== 1'b0 || rd !== 32'h0) begin
      n_bad++; $display("FAIL sb_resp: got %b/%h want 0/0", flt, rd); end
    n_cmp++; if (mem[5] !== 32'h1122_9944) begin
      n_bad++; $display("FAIL sb_mem: got %h want 11229944", mem[5]); end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL resp_pulse: got valid %b ready %b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_sh_sw();
    int lat, el; logic [31:0] rd, er; logic flt, ef; logic [7:0] wm, rm, ew;
    poke(8, 32'h0);
    model(1'b1, SH, 32'h22, 32'h0000_BEEF, er, ef, el, ew);
    issue(1'b1, SH, 32'h22, 32'h0000_BEEF, lat, rd, flt, wm, rm);
    n_cmp++; if (mem[8] !== 32'hBEEF_0000 || lat !== 3 || flt !== 1'b0) begin
      n_bad++; $display("FAIL sh: got mem %h lat %0d flt %b want beef0000/3/0", mem[8], lat, flt); end
    model(1'b1, SW, 32'h24, 32'hDEAD_BEEF, er, ef, el, ew);
    issue(1'b1, SW, 32'h24, 32'hDEAD_BEEF, lat, rd, flt, wm, rm);
    n_cmp++; if (mem[9] !== 32'hDEAD_BEEF || lat !== 2 || wm !== 8'b0000_0010 || flt !== 1'b0) begin
      n_bad++; $display("FAIL sw: got mem %h lat %0d we %b flt %b want deadbeef/2/10/0", mem[9], lat, wm, flt); end
  endtask

  task automatic test_faults();
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{LW, SH, 3'b011, SW};
    logic [31:0] adr [4] = '{32'h102, 32'h003, 32'h010, 32'h400};
    int lat, diffs; logic [31:0] rd; logic flt; logic [7:0] wm, rm;
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], f3s[i], adr[i], $urandom, lat, rd, flt, wm, rm);
      n_cmp++; if (flt !== 1'b1 || rd !== 32'h0) begin
        n_bad++; $display("FAIL fault[%0d]: got flt %b rdata %h want 1/0", i, flt, rd); end
      n_cmp++; if (lat !== 1 || wm !== 8'h0) begin
        n_bad++; $display("FAIL fault_timing[%0d]: got lat %0d we %b want 1/0", i, lat, wm); end
    end
    diffs = 0;
    for (int j = 0; j < int'(DEPTH); j++) if (mem[j] !== ref_mem[j]) diffs++;
    n_cmp++; if (diffs !== 0) begin n_bad++; $display("FAIL fault_mem: got %0d changed words want 0", diffs); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [31:0] expq[$];
    logic [31:0] e;
    int nresp;
    nresp = 0;
    repeat (2) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = {22'h0, 8'($urandom), 2'b00};
    for (int c = 0; c < 17; c++) begin
      if (resp_valid) begin
        nresp++;
        e = (expq.size() > 0) ? expq.pop_front() : 32'hxxxx_xxxx;
        n_cmp++; if (resp_rdata !== e || resp_fault !== 1'b0) begin
          n_bad++; $display("FAIL b2b_data: got %h/%b want %h/0", resp_rdata, resp_fault, e); end
      end
      if (c < 13 && req_ready) begin
        acc.push_back(c);
        expq.push_back(ref_mem[req_addr[9:2]]);
      end
      @(negedge clk);
      if (c < 12) req_addr = {22'h0, 8'($urandom), 2'b00};
      else req_valid = 1'b0;
    end
    n_cmp++; if (acc.size() !== 5 || nresp !== 5) begin
      n_bad++; $display("FAIL b2b_count: got %0d accepts %0d resps want 5/5", acc.size(), nresp); end
    for (int i = 1; i < acc.size(); i++) begin
      n_cmp++; if (acc[i] - acc[i-1] !== 3) begin
        n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_random();
    int lat, el, idx; logic [31:0] rd, er, a, wd; logic flt, ef, we; logic [2:0] f3; logic [7:0] wm, rm, ew;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 300)) : int'($urandom_range(0, 255));
      a = {idx[29:0], 2'($urandom)};
      wd = $urandom;
      model(we, f3, a, wd, er, ef, el, ew);
      issue(we, f3, a, wd, lat, rd, flt, wm, rm);
      n_cmp++; if (rd !== er || flt !== ef) begin
        n_bad++; $display("FAIL rand[%0d] we=%b f3=%0d a=%h: got %h/%b want %h/%b", n, we, f3, a, rd, flt, er, ef); end
      n_cmp++; if (lat !== el || wm !== ew || rm !== 8'h0) begin
        n_bad++; $display("FAIL rand_timing[%0d]: got lat %0d we %b rdy %b want %0d/%b/0", n, lat, wm, rm, el, ew); end
      if (idx < int'(DEPTH)) begin
        n_cmp++; if (mem[idx] !== ref_mem[idx]) begin
          n_bad++; $display("FAIL rand_mem[%0d] word %0d: got %h want %h", n, idx, mem[idx], ref_mem[idx]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic flt, seen; logic [7:0] wm, rm;
    for (int t = 0; t < 2; t++) begin
      poke(20 + t, 32'h5566_7788 + t);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = (t == 0) ? SB : SW;
      req_addr = (t == 0) ? 32'h51 : 32'h54; req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n_cmp++; if (mem_we !== t[0]) begin
        n_bad++; $display("FAIL mid_exec_we[%0d]: got %b want %b", t, mem_we, t[0]); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (mem_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++; $display("FAIL mid_reset[%0d]: got we %b valid %b ready %b want 0/0/1", t, mem_we, resp_valid, req_ready); end
      seen = 1'b0;
      repeat (3) begin @(negedge clk); seen |= resp_valid; end
      rst_n = 1'b1;
      repeat (2) begin @(negedge clk); seen |= resp_valid; end
      n_cmp++; if (seen !== 1'b0 || req_ready !== 1'b1) begin
        n_bad++; $display("FAIL mid_after[%0d]: got resp seen %b ready %b want 0/1", t, seen, req_ready); end
      n_cmp++; if (mem[20 + t] !== 32'h5566_7788 + t) begin
        n_bad++; $display("FAIL mid_mem[%0d]: got %h want %h", t, mem[20 + t], 32'h5566_7788 + t); end
      issue(1'b0, LW, 32'(80 + 4 * t), 32'h0, lat, rd, flt, wm, rm);
      n_cmp++; if (rd !== 32'h5566_7788 + t || lat !== 2 || flt !== 1'b0) begin
        n_bad++; $display("FAIL mid_reload[%0d]: got %h lat %0d want %h/2", t, rd, lat, 32'h5566_7788 + t); end
    end
  endtask

  initial begin
    rst_n = 1'b0; poke_en = 1'b0; poke_idx = 8'h0; poke_val = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h40; req_wdata = 32'h0;
    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) poke(i, $urandom);
    test_reset();
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    test_load_ext();
    test_sb_rmw();
    test_sh_sw();
    test_faults();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
